// File: rtl/wb_sequencer.sv
// -----------------------------------------------------------------------------
// wb_sequencer
//
// Write-back sequencer for the single register-file write port (AD3/WE3/WD3).
// Single-cycle ALU results always win the port. Long-latency results (loads,
// mul/div) arrive over a valid/ready handshake. They are buffered in a small
// FIFO and drained whenever the ALU leaves the port free. A per-register
// pending mask tells the hazard unit which writes are still in flight.
//
// Ordering rule: an ALU result is younger than every buffered or concurrently
// offered long-latency result. An ALU write to xN therefore kills (marks dead)
// every queued entry for xN. It also discards a same-cycle long-latency result
// for xN.
//
// Optional feature (macro WB_BYPASS_EN):
//   When defined, a long-latency result skips the FIFO and goes straight to the
//   write port if all of the following hold:
//     - the FIFO is empty,
//     - no ALU write is selected,
//     - the result's rd is non-zero.
//   This gives a latency of 1. When undefined, every long-latency result goes
//   through the FIFO.
//
// Parameters:
//   DEPTH      FIFO entries for long-latency results (power of two, >= 2)
//
// Ports:
//   clk        clock; all state updates on posedge
//   rst        synchronous active-high reset
//   alu_valid  ALU result present this cycle (never stalled)
//   alu_rd     ALU destination register
//   alu_data   ALU result
//   lu_valid   long-latency result offered
//   lu_ready   sequencer can accept a long-latency result
//   lu_rd      long-latency destination register
//   lu_data    long-latency result
//   AD3        register-file write address (registered)
//   WE3        register-file write enable (registered)
//   WD3        register-file write data (registered)
//   pending    bit r set = a write to xr is still in flight; bit 0 always 0
// -----------------------------------------------------------------------------
module wb_sequencer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        lu_valid,
   output logic        lu_ready,
   input  logic [4:0]  lu_rd,
   input  logic [31:0] lu_data,
   output logic [4:0]  AD3,
   output logic        WE3,
   output logic [31:0] WD3,
   output logic [31:0] pending
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

   // FIFO storage: one live flag, destination and data per entry
   logic [DEPTH-1:0] r_live;
   logic [4:0]       r_rd   [DEPTH];
   logic [31:0]      r_data [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;   // includes dead entries still occupying slots

   // Registered write port
   logic [4:0]       r_ad3;
   logic             r_we3;
   logic [31:0]      r_wd3;

   // Per-cycle decisions
   logic             w_alu_sel;
   logic             w_accept;
   logic             w_lu_killed;
   logic             w_fifo_empty;
   logic             w_pop;
   logic             w_bypass;
   logic             w_push;
   logic             w_head_live;
   logic [4:0]       w_head_rd;
   logic [31:0]      w_head_data;
   logic [31:0]      w_entry_dec [DEPTH];
   logic [31:0]      w_pending;

   // Ready depends only on current state (and reset), never on a same-cycle pop
   assign lu_ready     = !rst && (r_count < DEPTH_C);

   assign w_alu_sel    = alu_valid && (alu_rd != 5'd0);
   assign w_accept     = lu_valid && lu_ready;
   // A concurrently offered result for the same register is older than the ALU
   // write, so it is accepted and then dropped.
   assign w_lu_killed  = w_alu_sel && (lu_rd == alu_rd);
   assign w_fifo_empty = (r_count == '0);
   assign w_pop        = !w_alu_sel && !w_fifo_empty;

`ifdef WB_BYPASS_EN
   assign w_bypass     = w_accept && (lu_rd != 5'd0) && w_fifo_empty && !w_alu_sel;
`else
   assign w_bypass     = 1'b0;
`endif

   // Results for x0 and killed results are accepted but never stored
   assign w_push       = w_accept && (lu_rd != 5'd0) && !w_lu_killed && !w_bypass;

   assign w_head_live  = r_live[r_rptr];
   assign w_head_rd    = r_rd[r_rptr];
   assign w_head_data  = r_data[r_rptr];

   // -------------------------------------------------------------------------
   // FIFO state
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_live  <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            // Slot being written: becomes live. A killed result is never pushed,
            // so push and kill cannot target the same slot.
            if (w_push && (r_wptr == AW'(i))) begin
               r_live[i] <= 1'b1;
               r_rd[i]   <= lu_rd;
               r_data[i] <= lu_data;
            end else if (w_pop && (r_rptr == AW'(i))) begin
               // A freed slot must not contribute to pending
               r_live[i] <= 1'b0;
            end else if (w_alu_sel && (r_rd[i] == alu_rd)) begin
               // A younger ALU write supersedes any queued write to that register
               r_live[i] <= 1'b0;
            end
         end

         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end

         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW + 1)'(1);
            2'b01:   r_count <= r_count - (AW + 1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Write-port selection: ALU first, then FIFO head, then optional bypass
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ad3 <= '0;
         r_we3 <= 1'b0;
         r_wd3 <= '0;
      end else if (w_alu_sel) begin
         r_ad3 <= alu_rd;
         r_we3 <= 1'b1;
         r_wd3 <= alu_data;
      end else if (w_pop) begin
         // A dead head still consumes the port slot but performs no write
         r_ad3 <= w_head_rd;
         r_we3 <= w_head_live;
         r_wd3 <= w_head_data;
      end else if (w_bypass) begin
         r_ad3 <= lu_rd;
         r_we3 <= 1'b1;
         r_wd3 <= lu_data;
      end else begin
         r_we3 <= 1'b0;
      end
   end

   assign AD3 = r_ad3;
   assign WE3 = r_we3;
   assign WD3 = r_wd3;

   // -------------------------------------------------------------------------
   // Pending mask: built from registered state only
   // -------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_dec
         assign w_entry_dec[gi] = r_live[gi] ? (32'd1 << r_rd[gi]) : 32'd0;
      end
   endgenerate

   always_comb begin
      w_pending = '0;
      if (r_we3) begin
         w_pending = 32'd1 << r_ad3;
      end
      for (int i = 0; i < DEPTH; i++) begin
         w_pending = w_pending | w_entry_dec[i];
      end
      w_pending[0] = 1'b0;
   end

   assign pending = w_pending;

endmodule

// File: tb/tb_wb_sequencer.sv
// Testbench for wb_sequencer.
// The reference model is a queue of pending long-latency results. It is
// advanced once per clock using the sequencer's ordering and priority rules.
module tb_wb_sequencer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_rd;
   logic [31:0] lu_data;
   logic [4:0]  AD3;
   logic        WE3;
   logic [31:0] WD3;
   logic [31:0] pending;

   wb_sequencer #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .lu_valid  (lu_valid),
      .lu_ready  (lu_ready),
      .lu_rd     (lu_rd),
      .lu_data   (lu_data),
      .AD3       (AD3),
      .WE3       (WE3),
      .WD3       (WD3),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      bit        live;
      bit [4:0]  rd;
      bit [31:0] data;
   } ent_t;

   ent_t      q[$];
   bit        exp_we;
   bit        exp_known;
   bit [4:0]  exp_ad;
   bit [31:0] exp_wd;
   int        checks   = 0;
   int        failures = 0;
   int        cyc      = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit [31:0] model_pending();
      bit [31:0] m = 32'd0;
      if (exp_we) m[exp_ad] = 1'b1;
      foreach (q[i]) if (q[i].live) m[q[i].rd] = 1'b1;
      m[0] = 1'b0;
      return m;
   endfunction

   task automatic model_step(input bit r, input bit av, input bit [4:0] ard, input bit [31:0] ad,
                             input bit lv, input bit [4:0] lrd, input bit [31:0] ld);
      int   n0 = q.size();
      bit   alu;
      bit   acc;
      bit   byp;
      ent_t e;
      if (r) begin
         q.delete();
         exp_we = 1'b0; exp_ad = 5'd0; exp_wd = 32'd0; exp_known = 1'b1;
      end else begin
         alu = av && (ard != 5'd0);
         acc = lv && (n0 < DEPTH);
         exp_we = 1'b0;
         exp_known = 1'b0;
         if (alu) begin
            foreach (q[i]) if (q[i].rd == ard) q[i].live = 1'b0;
            exp_we = 1'b1; exp_ad = ard; exp_wd = ad; exp_known = 1'b1;
         end else if (n0 > 0) begin
            e = q.pop_front();
            exp_we = e.live; exp_ad = e.rd; exp_wd = e.data; exp_known = e.live;
         end
         if (acc && (lrd != 5'd0) && !(alu && (lrd == ard))) begin
`ifdef WB_BYPASS_EN
            byp = (n0 == 0) && !alu;
`else
            byp = 1'b0;
`endif
            if (byp) begin
               exp_we = 1'b1; exp_ad = lrd; exp_wd = ld; exp_known = 1'b1;
            end else begin
               q.push_back({1'b1, lrd, ld});
            end
         end
      end
   endtask

   // One clock of stimulus; checks ready, then the registered outputs after the edge
   task automatic cycle(input bit r, input bit av, input bit [4:0] ard, input bit [31:0] ad,
                        input bit lv, input bit [4:0] lrd, input bit [31:0] ld);
      bit exp_ready;
      rst = r; alu_valid = av; alu_rd = ard; alu_data = ad;
      lu_valid = lv; lu_rd = lrd; lu_data = ld;
      #1;
      exp_ready = !r && (q.size() < DEPTH);
      check("lu_ready", lu_ready, 32'(exp_ready));
      model_step(r, av, ard, ad, lv, lrd, ld);
      @(posedge clk);
      #1;
      cyc++;
      check("WE3", WE3, 32'(exp_we));
      if (exp_known) begin
         check("AD3", AD3, 32'(exp_ad));
         check("WD3", WD3, exp_wd);
      end
      check("pending", pending, model_pending());
      $display("cyc %0d rst=%0b alu=%0b x%0d lu=%0b x%0d -> WE3=%0b AD3=%0d WD3=%h pending=%h",
               cyc, r, av, ard, lv, lrd, WE3, AD3, WD3, pending);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   initial begin
      // Reset held two cycles with a long-latency offer present
      cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
      cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
      check("rst_WE3", WE3, 32'd0);
      check("rst_pending", pending, 32'd0);
      check("rst_AD3", AD3, 32'd0);
      idle(1);

      // ALU path, including a write to x0
      cycle(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
      check("alu_AD3", AD3, 32'd5);
      check("alu_WD3", WD3, 32'h1234);
      check("alu_WE3", WE3, 32'd1);
      cycle(1'b0, 1'b1, 5'd0, 32'h9999, 1'b0, 5'd0, 32'd0);
      check("alu_x0_WE3", WE3, 32'd0);

      // Contention: ALU busy on x1 while rd 2..5 are queued
      for (int k = 2; k <= 5; k++)
         cycle(1'b0, 1'b1, 5'd1, 32'h100 + 32'(k), 1'b1, 5'(k), 32'h200 + 32'(k));
      check("cont_pending", pending, 32'h3E);
      check("cont_ready", lu_ready, 32'd0);
      cycle(1'b0, 1'b1, 5'd1, 32'h1FF, 1'b1, 5'd6, 32'h206);
      for (int k = 2; k <= 5; k++) begin
         cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
         check("drain_AD3", AD3, 32'(k));
         check("drain_WD3", WD3, 32'h200 + 32'(k));
      end
      idle(1);

      // Kill: queued x7 superseded by a younger ALU write
      cycle(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'hAA);
      cycle(1'b0, 1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0);
      check("kill_AD3", AD3, 32'd7);
      check("kill_WD3", WD3, 32'hBB);
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      check("kill_dead_WE3", WE3, 32'd0);
      check("kill_pending", pending, 32'd0);

      // Same-cycle conflict on x9
      cycle(1'b0, 1'b1, 5'd9, 32'd1, 1'b1, 5'd9, 32'd2);
      check("conf_WD3", WD3, 32'd1);
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      check("conf_WE3", WE3, 32'd0);

      // Long-latency latency on an idle sequencer
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33);
`ifdef WB_BYPASS_EN
      check("lat_WE3_n1", WE3, 32'd1);
      check("lat_AD3_n1", AD3, 32'd3);
`else
      check("lat_WE3_n1", WE3, 32'd0);
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      check("lat_WE3_n2", WE3, 32'd1);
      check("lat_AD3_n2", AD3, 32'd3);
`endif
      idle(1);

      // Reset with three entries queued
      for (int k = 10; k <= 12; k++)
         cycle(1'b0, 1'b1, 5'd1, 32'h5, 1'b1, 5'(k), 32'(k));
      cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd13, 32'd13);
      check("mrst_WE3", WE3, 32'd0);
      check("mrst_pending", pending, 32'd0);
      idle(2);
      check("mrst_after_WE3", WE3, 32'd0);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 39) == 0),
               ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)), $urandom,
               ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 7)), $urandom);
      end
      idle(DEPTH + 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wb_sequencer.md
# wb_sequencer

Write-back sequencer driving the single register-file write port (AD3/WE3/WD3). It merges single-cycle ALU results with results from long-latency units (loads, mul/div) that arrive via a valid/ready handshake. Long-latency results are buffered in a small FIFO when the port is busy. A per-register pending mask is exported to the hazard unit.

## Interface
- DEPTH, 4: FIFO entries for long-latency results; power of two, ≥2
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle; always accepted, never stalled
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- lu_valid  in  1  long-latency result offered
- lu_ready  out  1  sequencer can accept a long-latency result
- lu_rd  in  5  long-latency destination register
- lu_data  in  32  long-latency result
- AD3  out  5  register-file write address (registered)
- WE3  out  1  register-file write enable (registered)
- WD3  out  32  register-file write data (registered)
- pending  out  32  bit r = write to xr still in flight; bit 0 always 0

## Operation
- Handshake: a long-latency result is accepted when lu_valid && lu_ready.
  - lu_ready = !rst && (count < DEPTH), derived from current state only.
  - A pop in the same cycle does not raise lu_ready.
  - If lu_rd == 0, the result is accepted and discarded (not enqueued).
- FIFO entry: {live, rd, data}. count includes dead entries.
- Per-cycle selection, in priority order:
  - (1) alu_valid && alu_rd != 0: ALU write.
  - (2) FIFO head present: pop the head. It writes if live; if dead, no write (WE3=0 next cycle).
  - (3) Nothing: WE3=0.
- The selection is registered into AD3/WE3/WD3 at the next edge. Writes to x0 never assert WE3.
- Ordering: an ALU result is younger than every buffered or concurrently offered long-latency result.
  - An ALU write to rd X clears `live` on every FIFO entry with rd == X in the same cycle.
  - A long-latency result accepted in the same cycle with lu_rd == X is accepted and discarded.
- Simultaneous push and pop on a non-full FIFO: both occur. count is unchanged.
- pending = decode(AD3 when WE3) | decode(rd of every live FIFO entry); bit 0 is forced to 0.
  - Registered state only; no combinational path from the inputs.

## Timing
- Reset values: AD3=0, WE3=0, WD3=0, pending=0, count=0, all entries dead; lu_ready=0 while rst is high.
- ALU path: alu_valid in cycle N → WE3 in cycle N+1 → regfile updated at the edge ending N+1.
- Long-latency path, FIFO empty and no ALU contention: accepted in N, enqueued at the edge ending N, popped in N+1, WE3 in N+2.
- Throughput: one write per cycle. Under continuous alu_valid the FIFO does not drain; lu_ready drops once count reaches DEPTH.
- Wrap-around: read and write pointers are log2(DEPTH) bits wide and wrap naturally. count is log2(DEPTH)+1 bits wide.
- Reset mid-operation: the FIFO is flushed and buffered results are lost. WE3=0 in the cycle after rst is sampled high, and stays 0 until rst falls.

## Configuration
- WB_BYPASS_EN defined:
  - Condition: the FIFO is empty, no ALU write is selected, and an accepted long-latency result has lu_rd != 0.
  - That result goes straight to AD3/WE3/WD3 at the next edge and is not enqueued (latency 1).
  - pending reflects it through AD3 only.
- WB_BYPASS_EN undefined: every long-latency result goes through the FIFO (latency ≥2).

## Test plan
- Reset: hold rst for 2 cycles with lu_valid=1 → WE3=0, pending=0, lu_ready=0; lu_ready=1 in the first cycle after rst falls.
- ALU only: alu_valid with rd=5, data=0x1234 in cycle N → AD3=5, WE3=1, WD3=0x1234 in N+1. With rd=0 → WE3=0.
- Contention: alu_valid continuous on rd=1; push lu rd=2..5 (DEPTH=4) → lu_ready=0 after the 4th push, pending=0x3C|0x2. Drop alu_valid → rd 2,3,4,5 written on consecutive cycles in order.
- Kill:
  - Enqueue lu rd=7 data=0xAA while ALU is busy, then send ALU rd=7 data=0xBB → one write of 0xBB to x7.
  - The dead entry later pops with WE3=0, and pending[7] clears after the ALU write.
- Same-cycle conflict: alu rd=9 data=1 and lu rd=9 data=2 accepted together → only data=1 is written to x9; count is unchanged.
- Bypass/mid-reset: with WB_BYPASS_EN, lu rd=3 on an idle sequencer in N → WE3 in N+1; without the macro, WE3 in N+2. Assert rst with 3 entries queued → no further writes, count=0.
